// File: rtl/prbs_xnor_checker.sv
// Receive-side checker for an XNOR-feedback LFSR bit stream: self-seeds from the
// incoming bits, locks after a run of correct predictions, then counts bit errors.
module prbs_xnor_checker #(
  parameter int                 width_p           = 8,
  parameter logic [width_p-1:0] taps_p            = width_p'(8'hB8),
  parameter int                 lock_count_p      = 16,
  parameter int                 unlock_errors_p   = 4,
  parameter int                 err_count_width_p = 16
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         valid_i,
  input  logic                         data_i,
  output logic                         ready_o,
  input  logic                         clear_i,
  output logic                         locked_o,
  output logic                         err_o,
  output logic [err_count_width_p-1:0] err_count_o
);

  localparam int seed_w  = $clog2(width_p + 1);
  localparam int match_w = $clog2(lock_count_p + 1);
  localparam int cerr_w  = $clog2(unlock_errors_p + 1);

  localparam logic [seed_w-1:0]  seed_last  = seed_w'(width_p - 1);
  localparam logic [match_w-1:0] match_last = match_w'(lock_count_p - 1);
  localparam logic [cerr_w-1:0]  cerr_last  = cerr_w'(unlock_errors_p - 1);

  typedef enum logic [1:0] {
    SEED    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t                       state_reg;
  logic [width_p-1:0]           sr_reg;
  logic [seed_w-1:0]            seed_cnt_reg;
  logic [match_w-1:0]           match_cnt_reg;
  logic [cerr_w-1:0]            consec_err_reg;
  logic                         locked_reg;
  logic                         err_reg;
  logic [err_count_width_p-1:0] err_count_reg;

  logic accept;
  logic predicted;
  logic mismatch;
  logic sr_all_ones;
  logic count_err;

  // The checker only refuses bits while reset is held.
  assign ready_o     = ~reset_i;
  assign accept      = valid_i & ready_o;
  assign predicted   = ~^(sr_reg & taps_p);
  assign mismatch    = data_i ^ predicted;
  assign sr_all_ones = &sr_reg;
  assign count_err   = accept && (state_reg == LOCKED) && mismatch;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_reg      <= SEED;
      sr_reg         <= '0;
      seed_cnt_reg   <= '0;
      match_cnt_reg  <= '0;
      consec_err_reg <= '0;
      locked_reg     <= 1'b0;
      err_reg        <= 1'b0;
      err_count_reg  <= '0;
    end else begin
      err_reg <= count_err;

      // A clear never discards an error counted in the same cycle.
      if (clear_i) begin
        err_count_reg <= count_err ? err_count_width_p'(1) : '0;
      end else if (count_err && (err_count_reg != '1)) begin
        err_count_reg <= err_count_reg + err_count_width_p'(1);
      end

      if (accept) begin
        case (state_reg)
          SEED: begin
            sr_reg <= {sr_reg[width_p-2:0], data_i};
            if (seed_cnt_reg == seed_last) begin
              state_reg     <= ACQUIRE;
              seed_cnt_reg  <= '0;
              match_cnt_reg <= '0;
            end else begin
              seed_cnt_reg <= seed_cnt_reg + seed_w'(1);
            end
          end
          ACQUIRE: begin
            sr_reg <= {sr_reg[width_p-2:0], data_i};
            // All-ones is the XNOR lockup state and must never count toward lock.
            if (!mismatch && !sr_all_ones) begin
              if (match_cnt_reg == match_last) begin
                state_reg     <= LOCKED;
                locked_reg    <= 1'b1;
                match_cnt_reg <= '0;
              end else begin
                match_cnt_reg <= match_cnt_reg + match_w'(1);
              end
            end else begin
              match_cnt_reg <= '0;
            end
          end
          LOCKED: begin
            sr_reg <= {sr_reg[width_p-2:0], predicted};
            if (mismatch) begin
              if (consec_err_reg == cerr_last) begin
                state_reg      <= SEED;
                sr_reg         <= '0;
                seed_cnt_reg   <= '0;
                match_cnt_reg  <= '0;
                consec_err_reg <= '0;
                locked_reg     <= 1'b0;
              end else begin
                consec_err_reg <= consec_err_reg + cerr_w'(1);
              end
            end else begin
              consec_err_reg <= '0;
            end
          end
          default: state_reg <= SEED;
        endcase
      end
    end
  end

  assign locked_o    = locked_reg;
  assign err_o       = err_reg;
  assign err_count_o = err_count_reg;

endmodule

// File: tb/tb_prbs_xnor_checker.sv
// Directed bench for prbs_xnor_checker: golden XNOR stream, idle gaps, injected
// errors, unlock/relock, lockup guard and a 2-bit saturating counter instance.
module tb_prbs_xnor_checker;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        valid = 1'b0;
  logic        data = 1'b0;
  logic        clear = 1'b0;
  logic        ready, locked, err;
  logic [15:0] err_count;
  logic        ready2, locked2, err2;
  logic [1:0]  err_count2;

  int checks = 0;
  int failures = 0;

  logic [7:0] gen_sr;
  logic       b;
  logic       flip, clr, lock_exp;
  int         exp_cnt, exp_cnt2, last_i;

  always #5 clk = ~clk;

  prbs_xnor_checker dut (
    .clk_i(clk), .reset_i(reset), .valid_i(valid), .data_i(data), .ready_o(ready),
    .clear_i(clear), .locked_o(locked), .err_o(err), .err_count_o(err_count)
  );

  prbs_xnor_checker #(.err_count_width_p(2)) dut2 (
    .clk_i(clk), .reset_i(reset), .valid_i(valid), .data_i(data), .ready_o(ready2),
    .clear_i(clear), .locked_o(locked2), .err_o(err2), .err_count_o(err_count2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_state(input string tag, input logic exp_locked, input logic exp_err,
                           input int exp_c, input int exp_c2);
    chk({tag, "_locked"}, 32'(locked), 32'(exp_locked));
    chk({tag, "_err"}, 32'(err), 32'(exp_err));
    chk({tag, "_count"}, 32'(err_count), exp_c);
    chk({tag, "_count2"}, 32'(err_count2), exp_c2);
  endtask

  task automatic step(input logic v, input logic d, input logic c);
    valid = v;
    data  = d;
    clear = c;
    @(posedge clk);
    #1;
  endtask

  // Golden transmit-side generator: taps 8'hB8, seeded with zero.
  task automatic gen_bit(output logic bit_o);
    bit_o  = ~^(gen_sr & 8'hB8);
    gen_sr = {gen_sr[6:0], bit_o};
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    reset = 1'b0;
  endtask

  initial begin
    // Reset held with valid high and toggling data.
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(1'b1, k[0], 1'b0);
      chk("rst_ready", 32'(ready), 0);
      chk_state("rst", 1'b0, 1'b0, 0, 0);
    end
    reset = 1'b0;
    #1;
    chk("rel_ready", 32'(ready), 1);

    // Golden stream, contiguous: lock after the 24th bit, no errors.
    gen_sr = 8'h00;
    for (int i = 1; i <= 100; i++) begin
      gen_bit(b);
      step(1'b1, b, 1'b0);
      chk_state("golden", i >= 24, 1'b0, 0, 0);
    end
    $display("golden stream: 100 bits, locked=%0b count=%0d", locked, err_count);

    // Same stream with an idle cycle between every bit.
    do_reset();
    gen_sr = 8'h00;
    begin
      int n;
      n = 0;
      for (int cyc = 0; cyc < 120; cyc++) begin
        if (cyc % 2 == 1) begin
          step(1'b0, ~data, 1'b0);
        end else begin
          gen_bit(b);
          step(1'b1, b, 1'b0);
          n++;
        end
        chk_state("gapped", n >= 24, 1'b0, 0, 0);
      end
    end
    $display("gapped stream: 60 bits, locked=%0b", locked);

    // Injected errors; pass 1 adds clears, a 4-error unlock, relock and spaced errors.
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      gen_sr   = 8'h00;
      exp_cnt  = 0;
      exp_cnt2 = 0;
      last_i   = (pass == 0) ? 70 : 125;
      for (int i = 1; i <= last_i; i++) begin
        gen_bit(b);
        flip = (i == 40) || (i == 55) ||
               ((pass == 1) && (((i >= 72) && (i <= 75)) ||
                                ((i >= 113) && (i <= 121) && (i % 2 == 1))));
        clr  = (pass == 1) && ((i == 55) || (i == 71) || (i == 111));
        lock_exp = (i >= 24) && !((i >= 75) && (i < 99));
        if (clr) begin
          exp_cnt  = flip ? 1 : 0;
          exp_cnt2 = flip ? 1 : 0;
        end else if (flip) begin
          exp_cnt  = exp_cnt + 1;
          exp_cnt2 = (exp_cnt2 == 3) ? 3 : exp_cnt2 + 1;
        end
        step(1'b1, b ^ flip, clr);
        chk_state("errs", lock_exp, flip, exp_cnt, exp_cnt2);
        if (flip || clr)
          $display("pass %0d bit %0d flip=%0b clear=%0b -> locked=%0b err=%0b count=%0d count2=%0d",
                   pass, i, flip, clr, locked, err, err_count, err_count2);
        if ((pass == 1) && (i == 113)) begin
          step(1'b0, ~data, 1'b0);
          chk_state("idle_after_err", 1'b1, 1'b0, exp_cnt, exp_cnt2);
        end
      end
    end

    // Reset while locked with errors counted.
    reset = 1'b1;
    step(1'b1, 1'b1, 1'b0);
    chk("midrst_ready", 32'(ready), 0);
    chk_state("midrst", 1'b0, 1'b0, 0, 0);
    reset = 1'b0;

    // Constant ones must never lock.
    for (int i = 1; i <= 200; i++) begin
      step(1'b1, 1'b1, 1'b0);
      chk_state("ones", 1'b0, 1'b0, 0, 0);
    end
    $display("constant ones: 200 bits, locked=%0b count=%0d", locked, err_count);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
